// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shifter: shift-mode codes and FSM states.
package iter_shifter_pkg;

  localparam logic [1:0] SHIFT_SLL  = 2'b00;
  localparam logic [1:0] SHIFT_SRL  = 2'b01;
  localparam logic [1:0] SHIFT_SRA  = 2'b10;
  localparam logic [1:0] SHIFT_ROTL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// shift_step: one combinational barrel stage, shifting acc by k (0..STEP)
// positions in the selected mode.
//   acc   : value being shifted
//   mode  : SLL / SRL / SRA / ROTL
//   k     : shift distance for this stage
//   res_c : shifted value (combinational)
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  localparam int unsigned K_W  = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       mode,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] res_c
);

  always_comb begin
    res_c = acc;
    case (mode)
      SHIFT_SLL:  res_c = acc << k;
      SHIFT_SRL:  res_c = acc >> k;
      // Sign bit is preserved each stage, so repeated stages keep the original fill.
      SHIFT_SRA:  res_c = WIDTH'($signed(acc) >>> k);
      // k=0 gives a right shift by WIDTH, which yields zero and leaves acc intact.
      SHIFT_ROTL: res_c = (acc << k) | (acc >> (WIDTH - 32'(k)));
      default:    res_c = acc;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter, up to STEP bit positions per clock.
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   start            : request, accepted only while idle
//   mode/shamt/shift_in : operation, amount and operand, sampled with start
//   shift_out        : result, updated only on done (or cleared by reset)
//   busy             : operation in flight
//   done             : one-cycle result-valid pulse
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 1,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   shift_in,
  output logic [WIDTH-1:0]   shift_out,
  output logic               busy,
  output logic               done
);

  localparam int unsigned K_W = $clog2(STEP + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [K_W-1:0]     k_c;
  logic [SHAMT_W-1:0] rem_next_c;
  logic [WIDTH-1:0]   step_res_c;

  // Distance for this cycle: min(STEP, remaining).
  always_comb begin
    if (rem_q >= SHAMT_W'(STEP)) begin
      k_c = K_W'(STEP);
    end else begin
      k_c = K_W'(rem_q);
    end
    rem_next_c = rem_q - SHAMT_W'(k_c);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc   (acc_q),
    .mode  (mode_q),
    .k     (k_c),
    .res_c (step_res_c)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = shift_in;
          rem_d   = shamt;
          mode_d  = mode;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // shamt=0 still spends one cycle here with k=0.
        acc_d = step_res_c;
        rem_d = rem_next_c;
        if (rem_next_c == '0) begin
          out_d   = step_res_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign shift_out = out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: two instances (STEP=1 and STEP=4) share
// the stimulus; each has its own expected-result queue and done monitor.
module tb_iter_shifter;
  import iter_shifter_pkg::*;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic [SW-1:0] shamt;
  logic [W-1:0]  shift_in;
  logic [W-1:0]  out1, out4;
  logic          busy1, busy4, done1, done4;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  due;
  } exp_t;

  typedef struct {
    logic [1:0]   m;
    int           s;
    logic [W-1:0] x;
  } op_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iter_shifter #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .shamt(shamt),
    .shift_in(shift_in), .shift_out(out1), .busy(busy1), .done(done1)
  );

  iter_shifter #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .shamt(shamt),
    .shift_in(shift_in), .shift_out(out4), .busy(busy4), .done(done4)
  );

  // Reference: each result bit is chosen from the operand by the mode's rule.
  function automatic logic [W-1:0] ref_shift(logic [1:0] m, int s, logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (m)
        SHIFT_SLL: r[i] = (i - s >= 0) ? x[i-s] : 1'b0;
        SHIFT_SRL: r[i] = (i + s < W) ? x[i+s] : 1'b0;
        SHIFT_SRA: r[i] = (i + s < W) ? x[i+s] : x[W-1];
        default:   r[i] = x[(i - s + W) % W];
      endcase
    end
    return r;
  endfunction

  function automatic int lat(int s, int step);
    return (s == 0) ? 1 : (s + step - 1) / step;
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_n(string name, int unsigned act, int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop and compare whenever a DUT reports done.
  always @(negedge clk) begin
    if (!reset && done1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1 unexpected done: got out=%h want no done", out1);
      end else begin
        e1 = q1.pop_front();
        check("dut1 result", out1, e1.res);
        check_n("dut1 done cycle", cyc, e1.due);
        check("dut1 busy at done", W'(busy1), '0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done4) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL dut4 unexpected done: got out=%h want no done", out4);
      end else begin
        e4 = q4.pop_front();
        check("dut4 result", out4, e4.res);
        check_n("dut4 done cycle", cyc, e4.due);
      end
    end
  end

  // Drive a start now; the next rising edge accepts it.
  task automatic issue_now(logic [1:0] m, int s, logic [W-1:0] x);
    exp_t e;
    mode     = m;
    shamt    = SW'(s);
    shift_in = x;
    start    = 1'b1;
    e.res = ref_shift(m, s, x);
    e.due = cyc + 1 + lat(s, 1);
    q1.push_back(e);
    e.due = cyc + 1 + lat(s, 4);
    q4.push_back(e);
  endtask

  task automatic issue(logic [1:0] m, int s, logic [W-1:0] x);
    @(posedge clk); #1;
    issue_now(m, s, x);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy1 after accept", W'(busy1), W'(1));
    check("busy4 after accept", W'(busy4), W'(1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (q1.size() == 0 && q4.size() == 0) return;
      @(posedge clk);
    end
    total++; bad++;
    $display("FAIL wait_idle timeout: got pending=%0d/%0d want 0/0", q1.size(), q4.size());
    q1.delete();
    q4.delete();
  endtask

  op_t dir [12] = '{
    '{SHIFT_SLL,  2,  32'h0000_0001},
    '{SHIFT_SLL,  2,  32'hC000_0000},
    '{SHIFT_SLL,  2,  32'h4000_0000},
    '{SHIFT_SRA,  31, 32'h8000_0000},
    '{SHIFT_SRL,  31, 32'h8000_0000},
    '{SHIFT_ROTL, 1,  32'h8000_0001},
    '{SHIFT_ROTL, 17, 32'hFFFF_FFFF},
    '{SHIFT_SLL,  0,  32'h7FFF_FFFF},
    '{SHIFT_SRL,  0,  32'h7FFF_FFFF},
    '{SHIFT_SRA,  0,  32'h7FFF_FFFF},
    '{SHIFT_ROTL, 0,  32'h7FFF_FFFF},
    '{SHIFT_SLL,  31, 32'h0000_0003}
  };

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    mode     = '0;
    shamt    = '0;
    shift_in = '0;

    #12;
    check("reset out1", out1, '0);
    check("reset busy1", W'(busy1), '0);
    check("reset done1", W'(done1), '0);
    check("reset out4", out4, '0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases, including the shamt=0 and maximum-shamt corners.
    foreach (dir[i]) begin
      wait_idle();
      issue(dir[i].m, dir[i].s, dir[i].x);
    end

    // A start while busy is ignored; a start on the done cycle is accepted.
    wait_idle();
    issue(SHIFT_SLL, 8, 32'h0000_0001);
    mode     = SHIFT_SRL;
    shamt    = SW'(1);
    shift_in = 32'hFFFF_FFFF;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy1 during ignored start", W'(busy1), W'(1));
    begin : wait_done1
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (done1) disable wait_done1;
      end
      total++; bad++;
      $display("FAIL done1 timeout: got no done want done within 50 cycles");
    end
    issue_now(SHIFT_SRA, 3, 32'h8000_0010);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy1 after start on done cycle", W'(busy1), W'(1));

    // Reset mid-run discards the operation; nothing completes afterwards.
    wait_idle();
    issue(SHIFT_ROTL, 20, 32'h1234_5678);
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("mid-run reset out1", out1, '0);
    check("mid-run reset busy1", W'(busy1), '0);
    check("mid-run reset done1", W'(done1), '0);
    check("mid-run reset out4", out4, '0);
    check("mid-run reset busy4", W'(busy4), '0);
    check("mid-run reset done4", W'(done4), '0);
    q1.delete();
    q4.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (30) @(posedge clk);
    issue(SHIFT_SRL, 5, 32'hF000_00F0);

    // Randomised operations.
    for (int n = 0; n < 60; n++) begin
      wait_idle();
      issue(2'($urandom_range(3)), int'($urandom_range(31)), $urandom);
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Parametrised, multi-cycle successor to the fixed left-shift-by-2 unit.
- Shifts a WIDTH-bit operand by a run-time amount in SLL, SRL, SRA or ROTL mode, STEP bit positions per clock.
- Uses a start/busy/done handshake.
- Sits beside the ALU for variable shifts (sllv/srlv/srav) and replaces the branch/jump shift-left-2 instances, which call it with shamt=2.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, >=8.
- STEP, 1, maximum bit positions shifted per cycle; power of two, 1..WIDTH/2.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount port; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROTL; sampled with start.
- shamt  in  SHAMT_W  shift amount (0..WIDTH-1); sampled with start.
- shift_in  in  WIDTH  operand; sampled with start.
- shift_out  out  WIDTH  result; valid when done=1, held until the next done.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse, result valid.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, shift_out=0; internal acc, remaining and mode registers cleared. An in-flight operation is discarded and no done is produced for it.
- IDLE + start=1: latch acc<=shift_in, remaining<=shamt, mode_r<=mode; go to RUN; busy=1 next cycle.
- RUN, each cycle:
  - k = min(STEP, remaining); shift acc by k per mode_r; remaining <= remaining-k.
  - If remaining-k==0: shift_out <= shifted acc, done=1 for that one cycle, busy=0, go to IDLE.
- shamt=0: one RUN cycle with k=0; shift_out=shift_in, done 1 cycle after start.
- Latency start->done = max(1, ceil(shamt/STEP)) cycles.
  - STEP=1, shamt=31: 31 cycles. STEP=4, shamt=31: 8 cycles.
- Throughput: a new start may be accepted in the same cycle done is high, since state is IDLE then. Back-to-back operations therefore need no idle gap.
- start while busy=1 is ignored: no latch, no effect on the running operation.
- Mode semantics:
  - SLL: zero-fill from LSB.
  - SRL: zero-fill from MSB.
  - SRA: fill with bit WIDTH-1 of the latched operand, stable across steps since the sign is preserved.
  - ROTL: bits leaving the MSB re-enter at the LSB.
- Overflow: bits shifted out are discarded, with no flag. Results are always exactly WIDTH bits.
- shift_out changes only on a done cycle or on reset. Inputs are don't-care when not starting.

Decomposition:
- Shared package/include shift_defs:
  - mode constants SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROTL=2'b11;
  - state encodings ST_IDLE, ST_RUN.
- One combinational sub-module, shift_step (WIDTH, STEP): inputs acc, mode, k (0..STEP); output the acc shifted by k. This is a small barrel stage; the FSM, counter and handshake stay in iter_shifter.

Test Plan:
- SLL, shift_in=0x00000001, shamt=2 (STEP=1) -> done 2 cycles after start, shift_out=0x00000004. Repeat with 0xC0000000 -> 0x00000000 and 0x40000000 -> 0x00000000.
- SRA, shift_in=0x80000000, shamt=31 -> shift_out=0xFFFFFFFF; done after 31 cycles at STEP=1, after 8 cycles at STEP=4. SRL of the same operand -> 0x00000001.
- ROTL, shift_in=0x80000001, shamt=1 -> 0x00000003. ROTL 0xFFFFFFFF, shamt=17 -> 0xFFFFFFFF.
- shamt=0, shift_in=0x7FFFFFFF, any mode -> done 1 cycle after start, shift_out=0x7FFFFFFF.
- SLL 0x1, shamt=8 in flight; start with shamt=1 pulsed mid-run -> ignored, result 0x00000100 after 8 cycles. Then start issued on the done cycle is accepted.
- Reset asserted mid-run (cycle 3 of shamt=20) -> busy, done and shift_out go to 0 immediately; no done follows. A fresh start after reset release completes normally.
